// File: rtl/sum_7seg_display.sv
// Display end of the 4-bit adder: latches {cout,sum}, converts it to BCD by
// sequential double-dabble and scans two common-anode 7-segment digits.
module sum_7seg_display #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    bin_q, bin_d;
    logic [7:0]    bcd_q, bcd_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [CW-1:0] ref_q, ref_d;
    logic          sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic [3:0]    adj_hi, adj_lo;
    logic [12:0]   shifted;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Add-3 correction happens before the shift so each nibble stays decimal.
    always_comb begin
        adj_hi  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        adj_lo  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        shifted = {adj_hi, adj_lo, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = {cout, sum};
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = shifted[12:5];
                bin_d = shifted[4:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan runs free of the FSM; outputs are registered from the current digit.
    always_comb begin
        ref_d = (ref_q == LAST) ? '0 : ref_q + CW'(1);
        sel_d = (ref_q == LAST) ? ~sel_q : sel_q;
        if (!sel_q) begin
            an_d  = 2'b10;
            seg_d = enc(ones_q);
        end else begin
            an_d  = 2'b01;
            if (BLANK_LEADING && (tens_q == 4'd0)) begin
                seg_d = 7'b1111111;
            end else begin
                seg_d = enc(tens_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            ref_q   <= '0;
            sel_q   <= 1'b0;
            seg_q   <= 7'b1111111;
            an_q    <= 2'b11;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            ref_q   <= ref_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_sum_7seg_display.sv
// Scoreboard bench for sum_7seg_display: random loads/resets, decimal model,
// two instances covering both leading-zero modes.
module tb_sum_7seg_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] sum = 4'd0;
    logic       cout = 1'b0;

    logic       busy1, done1, busy0, done0;
    logic [6:0] seg1, seg0;
    logic [1:0] an1, an0;

    always #5 clk = ~clk;

    sum_7seg_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_blank (
        .clk(clk), .rst(rst), .load(load), .sum(sum), .cout(cout),
        .busy(busy1), .done(done1), .seg(seg1), .an(an1)
    );

    sum_7seg_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_zero (
        .clk(clk), .rst(rst), .load(load), .sum(sum), .cout(cout),
        .busy(busy0), .done(done0), .seg(seg0), .an(an0)
    );

    typedef struct {
        int v;
        int c;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int acc_k  = -100;
    int n_rst  = -1;
    bit rst_s  = 1'b0;

    logic [6:0] digit_seg [10];
    initial begin
        digit_seg[0] = 7'b1000000; digit_seg[1] = 7'b1111001;
        digit_seg[2] = 7'b0100100; digit_seg[3] = 7'b0110000;
        digit_seg[4] = 7'b0011001; digit_seg[5] = 7'b0010010;
        digit_seg[6] = 7'b0000010; digit_seg[7] = 7'b1111000;
        digit_seg[8] = 7'b0000000; digit_seg[9] = 7'b0010000;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: sees inputs at each rising edge, predicts commits.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_s = rst;
            if (rst) begin
                q.delete();
                acc_k = -100;
                n_rst = 0;
            end else begin
                if (n_rst >= 0) n_rst++;
                if (load && cyc >= acc_k + 7) begin
                    acc_k = cyc;
                    q.push_back('{v: int'({cout, sum}), c: cyc + 5});
                end
            end
        end
    end

    // Monitor: checks outputs mid-cycle, pops expectations on commit.
    initial begin
        int disp_v = 0;
        int nxt_v = 0;
        int nxt_cnt = 0;
        int sel, tens, ones;
        bit exp_done;
        logic [6:0] e1, e0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (n_rst < 0) continue;
            if (rst_s) begin
                disp_v = 0;
                nxt_cnt = 0;
                chk("rst_seg1", int'(seg1), 7'h7f);
                chk("rst_an1", int'(an1), 2'b11);
                chk("rst_seg0", int'(seg0), 7'h7f);
                chk("rst_an0", int'(an0), 2'b11);
                chk("rst_busy", int'(busy1), 0);
                chk("rst_done", int'(done1), 0);
                continue;
            end
            if (nxt_cnt > 0) begin
                nxt_cnt--;
                if (nxt_cnt == 0) disp_v = nxt_v;
            end
            sel  = ((n_rst - 1) / 4) % 2;
            tens = disp_v / 10;
            ones = disp_v % 10;
            if (sel == 0) begin
                e1 = digit_seg[ones];
                e0 = digit_seg[ones];
            end else begin
                e1 = (tens == 0) ? 7'h7f : digit_seg[tens];
                e0 = digit_seg[tens];
            end
            chk("an_blank", int'(an1), sel ? 2'b01 : 2'b10);
            chk("an_zero", int'(an0), sel ? 2'b01 : 2'b10);
            chk("seg_blank", int'(seg1), int'(e1));
            chk("seg_zero", int'(seg0), int'(e0));
            chk("busy1", int'(busy1), int'(cyc >= acc_k && cyc <= acc_k + 5));
            chk("busy0", int'(busy0), int'(cyc >= acc_k && cyc <= acc_k + 5));
            exp_done = (q.size() > 0) && (q[0].c == cyc);
            chk("done1", int'(done1), int'(exp_done));
            chk("done0", int'(done0), int'(exp_done));
            if (exp_done) begin
                e = q.pop_front();
                nxt_v = e.v;
                nxt_cnt = 2;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] v);
        sum  = v[3:0];
        cout = v[4];
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        step(12);
        do_load(5'd31);
        step(20);
        do_load(5'd9);
        step(20);
        do_load(5'd16);
        step(1);
        do_load(5'd25);
        step(20);
        do_load(5'd31);
        step(2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(12);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst  = 1'b1;
                load = 1'($urandom_range(0, 1));
                sum  = 4'($urandom_range(0, 15));
                step($urandom_range(1, 2));
                rst  = 1'b0;
                load = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                do_load(5'($urandom_range(0, 31)));
            end else begin
                step(1);
            end
        end
        step(20);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
